// File: rtl/imem_access_stage.sv
// Memory-access pipeline stage between execute and write-back.
// Loads and stores go out on a req/ack data bus. Load data is aligned and then
// sign- or zero-extended. Upstream is stalled while an access is in flight.
// Every instruction produces exactly one registered result bundle for write-back.
module imem_access_stage #(
  parameter int WORD    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              im_clk,
  input  logic              im_rst,
  input  logic              in_valid,
  input  logic [WORD-1:0]   pc_in,
  input  logic [WORD-1:0]   alu_result,
  input  logic [WORD-1:0]   store_data,
  input  logic [4:0]        write_register_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              reg_write_in,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD-1:0]   mem_addr,
  output logic [WORD/8-1:0] mem_be,
  output logic [WORD-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD-1:0]   mem_rdata,
  output logic              out_valid,
  output logic [WORD-1:0]   pc_out,
  output logic [WORD-1:0]   alu_result_out,
  output logic [WORD-1:0]   read_data,
  output logic [4:0]        write_register_out,
  output logic              MemtoReg_out,
  output logic              reg_write_out,
  output logic              mem_fault
);
  localparam int LANES = WORD / 8;
  localparam int AW    = $clog2(LANES);
  localparam int CW    = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [AW-1:0]   low_reg;
  logic [1:0]      size_reg;
  logic            signed_reg;
  logic            load_reg;

  logic [AW-1:0]   in_low;
  logic [31:0]     in_bytes;
  logic            is_mem;
  logic            bad_access;
  logic [LANES-1:0] in_lanes;
  logic [LANES-1:0] ld_lanes;
  logic [WORD-1:0] in_mask;
  logic [WORD-1:0] ld_mask;
  logic [WORD-1:0] ld_shifted;
  logic [WORD-1:0] ld_value;
  logic            ld_sign;

  assign in_low   = alu_result[AW-1:0];
  assign in_bytes = 32'd1 << mem_size;
  assign is_mem   = MemRead | MemWrite;
  // An access faults without touching the bus if it is both a load and a store,
  // if it is wider than the bus, or if it is not naturally aligned.
  assign bad_access = (MemRead & MemWrite) ||
                      (in_bytes > 32'(LANES)) ||
                      ((in_low & AW'(in_bytes - 32'd1)) != '0);
  assign stall = (state_reg == WAIT);

  // Lane masks: one bit per byte lane covered by the access size, starting at lane 0.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign in_lanes[gi] = (32'(gi) < in_bytes);
    assign ld_lanes[gi] = (32'(gi) < (32'd1 << size_reg));
  end
  for (genvar gi = 0; gi < WORD; gi++) begin : g_bit
    assign in_mask[gi] = in_lanes[gi/8];
    assign ld_mask[gi] = ld_lanes[gi/8];
  end

  assign ld_shifted = mem_rdata >> {low_reg, 3'b000};

  // Select the sign bit of the loaded field according to the latched size.
  always_comb begin
    ld_sign = 1'b0;
    case (size_reg)
      2'd0:    ld_sign = ld_shifted[7];
      2'd1:    ld_sign = ld_shifted[15];
      2'd2:    ld_sign = ld_shifted[31];
      default: ld_sign = ld_shifted[WORD-1];
    endcase
  end

  assign ld_value = (ld_shifted & ld_mask) | ((signed_reg & ld_sign) ? ~ld_mask : '0);

  // Stage FSM: accept in IDLE, hold bus outputs steady in WAIT, emit one bundle per op.
  always_ff @(posedge im_clk) begin
    if (im_rst) begin
      state_reg          <= IDLE;
      count_reg          <= '0;
      low_reg            <= '0;
      size_reg           <= '0;
      signed_reg         <= 1'b0;
      load_reg           <= 1'b0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_be             <= '0;
      mem_wdata          <= '0;
      out_valid          <= 1'b0;
      pc_out             <= '0;
      alu_result_out     <= '0;
      read_data          <= '0;
      write_register_out <= '0;
      MemtoReg_out       <= 1'b0;
      reg_write_out      <= 1'b0;
      mem_fault          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            pc_out             <= pc_in;
            alu_result_out     <= alu_result;
            write_register_out <= write_register_in;
            MemtoReg_out       <= MemtoReg;
            read_data          <= '0;
            if (is_mem && bad_access) begin
              out_valid     <= 1'b1;
              mem_fault     <= 1'b1;
              reg_write_out <= 1'b0;
            end else if (is_mem) begin
              state_reg     <= WAIT;
              count_reg     <= '0;
              mem_req       <= 1'b1;
              mem_we        <= MemWrite;
              mem_addr      <= {alu_result[WORD-1:AW], {AW{1'b0}}};
              mem_be        <= in_lanes << in_low;
              mem_wdata     <= (store_data & in_mask) << {in_low, 3'b000};
              low_reg       <= in_low;
              size_reg      <= mem_size;
              signed_reg    <= mem_signed;
              load_reg      <= MemRead;
              mem_fault     <= 1'b0;
              reg_write_out <= reg_write_in;
            end else begin
              out_valid     <= 1'b1;
              mem_fault     <= 1'b0;
              reg_write_out <= reg_write_in;
            end
          end
        end
        default: begin
          if (mem_ack) begin
            out_valid <= 1'b1;
            mem_req   <= 1'b0;
            state_reg <= IDLE;
            read_data <= load_reg ? ld_value : '0;
          end else if (count_reg == CW'(TIMEOUT - 1)) begin
            out_valid     <= 1'b1;
            mem_fault     <= 1'b1;
            reg_write_out <= 1'b0;
            mem_req       <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_access_stage.sv
// Bench for imem_access_stage: directed cases with literal expectations,
// followed by randomized traffic checked against a behavioural model.
module tb_imem_access_stage;
  localparam int WORD    = 64;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] pc_in, alu_result, store_data;
  logic [4:0]  write_register_in;
  logic        MemRead, MemWrite, MemtoReg, reg_write_in;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic        stall, mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic [63:0] pc_out, alu_result_out, read_data;
  logic [4:0]  write_register_out;
  logic        MemtoReg_out, reg_write_out, mem_fault;

  always #5 clk = ~clk;

  imem_access_stage #(.WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
    .im_clk(clk), .im_rst(rst), .in_valid(in_valid), .pc_in(pc_in),
    .alu_result(alu_result), .store_data(store_data),
    .write_register_in(write_register_in), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .reg_write_in(reg_write_in), .mem_size(mem_size),
    .mem_signed(mem_signed), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .pc_out(pc_out),
    .alu_result_out(alu_result_out), .read_data(read_data),
    .write_register_out(write_register_out), .MemtoReg_out(MemtoReg_out),
    .reg_write_out(reg_write_out), .mem_fault(mem_fault)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        fault;
    logic        bus;
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } plan_t;

  function automatic plan_t plan_access(input logic rd, input logic wr, input logic [1:0] size,
                                        input logic [63:0] ea, input logic [63:0] sd);
    plan_t p;
    int n, lo;
    p  = '0;
    n  = 1 << size;
    lo = int'(ea % 64'd8);
    if (!(rd || wr)) return p;
    if ((rd && wr) || (lo % n != 0) || (n > WORD / 8)) begin
      p.fault = 1'b1;
      return p;
    end
    p.bus  = 1'b1;
    p.we   = wr;
    p.addr = ea - 64'(lo);
    for (int b = 0; b < 8; b++) begin
      if (b >= lo && b < lo + n) begin
        p.be[b] = 1'b1;
        p.wdata[8*b +: 8] = sd[8*(b-lo) +: 8];
      end
    end
    return p;
  endfunction

  function automatic logic [63:0] load_value(input logic [63:0] word, input int lo,
                                             input logic [1:0] size, input logic sgn);
    logic [63:0] v;
    int n;
    v = '0;
    n = 1 << size;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(lo+i) +: 8];
    if (sgn && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- expected per-cycle state ----------------
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_valid = 1'b0;
  plan_t       exp_plan = '0;
  logic [63:0] e_pc, e_alu, e_rd;
  logic [4:0]  e_wreg;
  logic        e_m2r, e_rw, e_fault;
  int          stall_cnt = 0, req_cnt = 0;
  logic [7:0]  last_be;
  logic [63:0] last_wdata;
  logic        last_we;
  logic [63:0] lane_m;

  // Compare every cycle at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("mem_req", mem_req, exp_req);
      if (mem_req) begin
        req_cnt++;
        last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we;
      end
      if (stall) stall_cnt++;
      if (exp_req) begin
        chk("mem_we", mem_we, exp_plan.we);
        chk("mem_addr", mem_addr, exp_plan.addr);
        chk("mem_be", mem_be, exp_plan.be);
        if (exp_plan.we) begin
          for (int b = 0; b < 8; b++) lane_m[8*b +: 8] = {8{exp_plan.be[b]}};
          chk("mem_wdata", mem_wdata & lane_m, exp_plan.wdata);
        end
      end
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("pc_out", pc_out, e_pc);
        chk("alu_result_out", alu_result_out, e_alu);
        chk("read_data", read_data, e_rd);
        chk("write_register_out", write_register_out, e_wreg);
        chk("MemtoReg_out", MemtoReg_out, e_m2r);
        chk("reg_write_out", reg_write_out, e_rw);
        chk("mem_fault", mem_fault, e_fault);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic scramble();
    pc_in = {$urandom, $urandom}; alu_result = {$urandom, $urandom};
    store_data = {$urandom, $urandom}; write_register_in = 5'($urandom);
    MemRead = 1'($urandom); MemWrite = 1'($urandom); MemtoReg = 1'($urandom);
    reg_write_in = 1'($urandom); mem_size = 2'($urandom); mem_signed = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      scramble();
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      mem_ack = 1'b0;
      exp_valid = 1'b0;
    end
  endtask

  // One instruction; ack_at = WAIT cycle in which ack is raised (0: never),
  // rst_at = WAIT cycle in which reset is raised (0: never).
  task automatic txn(input logic rd, input logic wr, input logic m2r, input logic rw,
                     input logic [1:0] size, input logic sgn, input logic [63:0] ea,
                     input logic [63:0] sd, input logic [63:0] pcv, input logic [4:0] wreg,
                     input int ack_at, input logic [63:0] rword, input int rst_at);
    plan_t p;
    int lo;
    p  = plan_access(rd, wr, size, ea, sd);
    lo = int'(ea % 64'd8);
    in_valid = 1'b1; MemRead = rd; MemWrite = wr; MemtoReg = m2r; reg_write_in = rw;
    mem_size = size; mem_signed = sgn; alu_result = ea; store_data = sd; pc_in = pcv;
    write_register_in = wreg;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ack = 1'b0; scramble();
    e_pc = pcv; e_alu = ea; e_wreg = wreg; e_m2r = m2r; e_rd = '0;
    if (!p.bus) begin
      exp_valid = 1'b1; e_rw = rw & !p.fault; e_fault = p.fault;
      return;
    end
    exp_valid = 1'b0; exp_stall = 1'b1; exp_req = 1'b1; exp_plan = p;
    for (int k = 1; k <= TIMEOUT; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      if (k == rst_at) rst = 1'b1;
      if (k == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rword;
      end else begin
        mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; in_valid = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0;
        return;
      end
      if (k == ack_at) begin
        exp_valid = 1'b1; e_rw = rw; e_fault = 1'b0;
        e_rd = rd ? load_value(rword, lo, size, sgn) : 64'd0;
        exp_stall = 1'b0; exp_req = 1'b0;
        return;
      end
      if (k == TIMEOUT) begin
        exp_valid = 1'b1; e_rw = 1'b0; e_fault = 1'b1; e_rd = '0;
        exp_stall = 1'b0; exp_req = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int s0, r0, kind, ack_at, pick;
    logic rd, wr;
    logic [1:0] size;
    logic [63:0] ea, amask;

    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_mem_fault", mem_fault, 0);
    chk("rst_reg_write_out", reg_write_out, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Non-memory op, latency 1.
    txn(0, 0, 0, 1, 2'b11, 0, 64'h1234, 64'h0, 64'h400, 5'd5, 0, 64'h0, 0);
    chk("dir_nm_valid", out_valid, 1);
    chk("dir_nm_alu", alu_result_out, 64'h1234);
    chk("dir_nm_rdata", read_data, 0);
    chk("dir_nm_stall", stall, 0);
    idle(1);

    // Signed byte load at 0x103, ack in 3rd WAIT cycle.
    s0 = stall_cnt;
    txn(1, 0, 1, 1, 2'b00, 1, 64'h103, 64'h0, 64'h404, 5'd7, 3, 64'h0000_0000_8000_0000, 0);
    chk("dir_lb_be", last_be, 8'h08);
    chk("dir_lb_stall_cycles", 64'(stall_cnt - s0), 3);
    chk("dir_lb_rdata", read_data, 64'hFFFF_FFFF_FFFF_FF80);
    // Same, zero-extended.
    txn(1, 0, 1, 1, 2'b00, 0, 64'h103, 64'h0, 64'h408, 5'd7, 3, 64'h0000_0000_8000_0000, 0);
    chk("dir_lbu_rdata", read_data, 64'h80);
    idle(1);

    // Half store 0xBEEF at 0x6.
    txn(0, 1, 0, 0, 2'b01, 0, 64'h6, 64'hBEEF, 64'h40C, 5'd0, 2, 64'h0, 0);
    chk("dir_sh_be", last_be, 8'hC0);
    chk("dir_sh_wdata_hi", last_wdata[63:48], 16'hBEEF);
    chk("dir_sh_we", last_we, 1);
    chk("dir_sh_valid", out_valid, 1);
    chk("dir_sh_rw", reg_write_out, 0);
    idle(1);

    // Misaligned word load: no bus access, fault in one cycle.
    r0 = req_cnt;
    txn(1, 0, 1, 1, 2'b10, 0, 64'h2, 64'h0, 64'h410, 5'd9, 1, 64'h0, 0);
    chk("dir_mis_valid", out_valid, 1);
    chk("dir_mis_fault", mem_fault, 1);
    chk("dir_mis_rw", reg_write_out, 0);
    idle(1);
    chk("dir_mis_noreq", 64'(req_cnt - r0), 0);

    // Dword load never acknowledged: timeout fault after 16 WAIT edges.
    s0 = stall_cnt;
    txn(1, 0, 1, 1, 2'b11, 0, 64'h1000, 64'h0, 64'h414, 5'd3, 0, 64'h0, 0);
    chk("dir_to_stall_cycles", 64'(stall_cnt - s0), 16);
    chk("dir_to_fault", mem_fault, 1);
    chk("dir_to_valid", out_valid, 1);
    chk("dir_to_stall", stall, 0);
    idle(1);

    // Reset in the 2nd WAIT cycle, then a stray ack, then a normal op.
    txn(1, 0, 1, 1, 2'b11, 0, 64'h2000, 64'h0, 64'h418, 5'd4, 0, 64'h0, 2);
    chk("dir_rst_req", mem_req, 0);
    chk("dir_rst_valid", out_valid, 0);
    in_valid = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("dir_rst_stray_valid", out_valid, 0);
    txn(1, 0, 1, 1, 2'b10, 1, 64'h2004, 64'h0, 64'h41C, 5'd6, 1, 64'h1234_5678_0000_0000, 0);
    chk("dir_rst_next_valid", out_valid, 1);
    chk("dir_rst_next_rdata", read_data, 64'h0000_0000_1234_5678);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 99);
      rd = (kind < 45) || (kind >= 95);
      wr = (kind >= 45 && kind < 75) || (kind >= 95);
      if (kind >= 75 && kind < 95) begin rd = 1'b0; wr = 1'b0; end
      size = 2'($urandom);
      ea = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7) begin
        amask = 64'((1 << size) - 1);
        ea = ea & ~amask;
      end
      pick = $urandom_range(0, 99);
      if (pick < 3) ack_at = 0;
      else if (pick < 6) ack_at = TIMEOUT;
      else ack_at = $urandom_range(1, 4);
      txn(rd, wr, 1'($urandom), 1'($urandom), size, 1'($urandom), ea,
          {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), ack_at,
          {$urandom, $urandom}, 0);
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
